packet_reassembler: RTL and testbench

//  Receive-side counterpart of the TX segmenter: packs consecutive MTU-wide segments

---
 rtl/packet_reassembler.sv | 121 ++++++++++++
 tb/tb_packet_reassembler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/packet_reassembler.sv
// Purpose : packs consecutive MTU-wide segments from an AXI-Stream slave into
//           AXI_FRAME_SIZE-wide, MSB-first frames on an AXI-Stream master.
// Ports   : clk/rst (sync, active-high); s_axis_* segment input (tdata/tvalid/tlast/tready);
//           m_axis_* frame output (tdata/tvalid/tkeep/tlast/tready).
// Latency : frame valid the cycle after its last segment is accepted (N==1: combinational).
// Backpressure: s_axis_tready drops only while a frame is held and m_axis_tready is low.
// Option  : define REASM_TLAST_EN to let s_axis_tlast flush a partial, zero-padded frame.
module packet_reassembler #(
   parameter int MTU            = 64,
   parameter int AXI_FRAME_SIZE = 128
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [MTU-1:0]              s_axis_tdata,
   input  logic                        s_axis_tvalid,
   input  logic                        s_axis_tlast,
   output logic                        s_axis_tready,
   output logic [AXI_FRAME_SIZE-1:0]   m_axis_tdata,
   output logic                        m_axis_tvalid,
   output logic [AXI_FRAME_SIZE/8-1:0] m_axis_tkeep,
   output logic                        m_axis_tlast,
   input  logic                        m_axis_tready
);

   localparam int N  = AXI_FRAME_SIZE / MTU;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam int MB = MTU / 8;
   localparam int KW = AXI_FRAME_SIZE / 8;

   // Packet-end indication as seen by the packer; constant 0 when the feature is off.
   logic last_in;
`ifdef REASM_TLAST_EN
   assign last_in = s_axis_tlast;
`else
   logic unused_tlast;
   assign last_in      = 1'b0;
   assign unused_tlast = s_axis_tlast;
`endif

   if (MTU < 8 || (MTU % 8) != 0 || AXI_FRAME_SIZE < MTU || (AXI_FRAME_SIZE % MTU) != 0) begin : g_bad_cfg
      $error("packet_reassembler: AXI_FRAME_SIZE must be N*MTU (N>=1) and MTU a multiple of 8");
   end else if (N == 1) begin : g_pass
      // One segment is a whole frame: nothing to store.
      logic unused_clk;
      assign unused_clk    = clk ^ rst;
      assign m_axis_tdata  = s_axis_tdata;
      assign m_axis_tvalid = s_axis_tvalid;
      assign m_axis_tkeep  = '1;
      assign m_axis_tlast  = last_in;
      assign s_axis_tready = m_axis_tready;
   end else begin : g_pack
      logic [CW-1:0]                  seg_cnt;
      logic [AXI_FRAME_SIZE-MTU-1:0]  acc;       // segments 0..N-2, segment 0 at the top
      logic [AXI_FRAME_SIZE-1:0]      acc_ext;
      logic [AXI_FRAME_SIZE-1:0]      frame_nxt;
      logic [KW-1:0]                  keep_nxt;
      logic                           accept;
      logic                           send;
      logic                           complete;

      assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
      assign accept        = s_axis_tvalid && s_axis_tready;
      assign send          = m_axis_tvalid && m_axis_tready;
      assign complete      = accept && ((seg_cnt == CW'(N-1)) || last_in);

      // Padding the accumulator to frame width lets every slot use the same slice index.
      assign acc_ext = {acc, {MTU{1'b0}}};

      // Slots below seg_cnt come from the accumulator, slot seg_cnt is the incoming
      // segment, later slots are forced to zero so stale accumulator bits never leak.
      always_comb begin
         frame_nxt = '0;
         keep_nxt  = '0;
         for (int i = 0; i < N; i++) begin
            if (i < int'(seg_cnt)) begin
               frame_nxt[AXI_FRAME_SIZE-1-i*MTU -: MTU] = acc_ext[AXI_FRAME_SIZE-1-i*MTU -: MTU];
            end else if (i == int'(seg_cnt)) begin
               frame_nxt[AXI_FRAME_SIZE-1-i*MTU -: MTU] = s_axis_tdata;
            end
            if (i <= int'(seg_cnt)) begin
               keep_nxt[KW-1-i*MB -: MB] = '1;
            end
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            seg_cnt       <= '0;
            acc           <= '0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
         end else begin
            if (accept) begin
               if (complete) begin
                  seg_cnt <= '0;
               end else begin
                  seg_cnt <= seg_cnt + 1'b1;
               end
               for (int i = 0; i < N-1; i++) begin
                  if (!complete && seg_cnt == CW'(i)) begin
                     acc[AXI_FRAME_SIZE-MTU-1-i*MTU -: MTU] <= s_axis_tdata;
                  end
               end
            end
            // A completing accept is only possible when the output slot is free or being
            // drained this cycle, so loading here never overwrites an unsent frame.
            if (complete) begin
               m_axis_tdata  <= frame_nxt;
               m_axis_tkeep  <= keep_nxt;
               m_axis_tlast  <= last_in;
               m_axis_tvalid <= 1'b1;
            end else if (send) begin
               m_axis_tvalid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_packet_reassembler.sv
// Purpose : randomized + directed bench for packet_reassembler (64/128 main instance,
//           32/128 four-segment instance, 64/64 pass-through instance).
// Ports   : none; honours REASM_TLAST_EN in its reference model.
module tb_packet_reassembler;

`ifdef REASM_TLAST_EN
   localparam bit TLAST_EN = 1'b1;
`else
   localparam bit TLAST_EN = 1'b0;
`endif
   localparam int N = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // 64/128 instance
   logic [63:0]  s_data;
   logic         s_valid, s_last, s_ready;
   logic [127:0] m_data;
   logic         m_valid, m_last, m_ready;
   logic [15:0]  m_keep;

   // 32/128 instance
   logic [31:0]  s1_data;
   logic         s1_valid, s1_last, s1_ready;
   logic [127:0] m1_data;
   logic         m1_valid, m1_last, m1_ready;
   logic [15:0]  m1_keep;

   // 64/64 pass-through instance
   logic [63:0]  s2_data;
   logic         s2_valid, s2_last, s2_ready;
   logic [63:0]  m2_data;
   logic         m2_valid, m2_last, m2_ready;
   logic [7:0]   m2_keep;

   packet_reassembler #(.MTU(64), .AXI_FRAME_SIZE(128)) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tlast(s_last), .s_axis_tready(s_ready),
      .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tkeep(m_keep), .m_axis_tlast(m_last),
      .m_axis_tready(m_ready));

   packet_reassembler #(.MTU(32), .AXI_FRAME_SIZE(128)) dut32 (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s1_data), .s_axis_tvalid(s1_valid), .s_axis_tlast(s1_last), .s_axis_tready(s1_ready),
      .m_axis_tdata(m1_data), .m_axis_tvalid(m1_valid), .m_axis_tkeep(m1_keep), .m_axis_tlast(m1_last),
      .m_axis_tready(m1_ready));

   packet_reassembler #(.MTU(64), .AXI_FRAME_SIZE(64)) dut_pt (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s2_data), .s_axis_tvalid(s2_valid), .s_axis_tlast(s2_last), .s_axis_tready(s2_ready),
      .m_axis_tdata(m2_data), .m_axis_tvalid(m2_valid), .m_axis_tkeep(m2_keep), .m_axis_tlast(m2_last),
      .m_axis_tready(m2_ready));

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference model: segments of the packet in progress, frames owed downstream.
   typedef struct {
      logic [127:0] data;
      logic [15:0]  keep;
      logic         last;
   } frame_t;

   logic [63:0] part_q[$];
   frame_t      exp_q[$];

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s1_valid = 1'b0; m1_ready = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      part_q.delete();
      exp_q.delete();
      chk("rst_valid", m_valid, 0);
      chk("rst_data",  m_data,  0);
      chk("rst_keep",  m_keep,  0);
      chk("rst_last",  m_last,  0);
      chk("rst32_valid", m1_valid, 0);
      chk("rst32_data",  m1_data,  0);
   endtask

   // One clock of traffic on the 64/128 instance, checked against the model.
   task automatic cycle(input logic v, input logic [63:0] d, input logic l, input logic mr);
      logic         acc, snd, held, pend;
      logic [127:0] held_dat;
      frame_t       f;
      @(negedge clk);
      s_valid = v; s_data = d; s_last = l; m_ready = mr;
      #1;
      chk("s_ready_rule", s_ready, !m_valid || mr);
      acc      = v && s_ready;
      snd      = m_valid && mr;
      held     = m_valid && !mr;
      held_dat = m_data;
      pend     = 1'b0;
      f        = '{default: '0};
      if (snd) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_frame", m_valid, 0);
         end else begin
            f = exp_q.pop_front();
            chk("frame_data", m_data, f.data);
            chk("frame_keep", m_keep, f.keep);
            chk("frame_last", m_last, f.last);
         end
      end
      if (acc) begin
         part_q.push_back(d);
         if (part_q.size() == N || (TLAST_EN && l)) begin
            f.data = '0;
            f.keep = '0;
            for (int i = 0; i < part_q.size(); i++) begin
               f.data[127-64*i -: 64] = part_q[i];
               f.keep[15-8*i -: 8]    = 8'hFF;
            end
            f.last = TLAST_EN && l;
            exp_q.push_back(f);
            part_q.delete();
            pend = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      if (pend) begin
         chk("lat_valid", m_valid, 1);
         chk("lat_data",  m_data,  f.data);
      end else if (held) begin
         chk("hold_valid", m_valid, 1);
         chk("hold_data",  m_data,  held_dat);
      end else if (snd) begin
         chk("drain_valid", m_valid, 0);
      end
   endtask

   initial begin
      rst = 1'b1;
      s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
      s1_valid = 1'b0; s1_data = '0; s1_last = 1'b0; m1_ready = 1'b0;
      s2_valid = 1'b0; s2_data = '0; s2_last = 1'b0; m2_ready = 1'b0;

      do_reset();

      // Back-to-back pair forms one frame, valid one cycle after the 2nd accept.
      cycle(1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 1'b1);
      cycle(1'b1, 64'hBBBB_BBBB_BBBB_BBBB, 1'b0, 1'b1);
      chk("t1_data", m_data, {64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB});
      chk("t1_keep", m_keep, 16'hFFFF);
      cycle(1'b0, 64'd0, 1'b0, 1'b1);

      // Continuous stream at full rate.
      for (int k = 1; k <= 8; k++) cycle(1'b1, 64'(k), 1'b0, 1'b1);
      cycle(1'b0, 64'd0, 1'b0, 1'b1);

      // Held frame under backpressure; the waiting segment must not be lost.
      cycle(1'b1, 64'h1, 1'b0, 1'b0);
      cycle(1'b1, 64'h2, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         cycle(1'b1, 64'h3, 1'b0, 1'b0);
         chk("t3_stall", s_ready, 0);
      end
      cycle(1'b1, 64'h3, 1'b0, 1'b1);
      cycle(1'b1, 64'h4, 1'b0, 1'b1);
      chk("t3_next", m_data, {64'h3, 64'h4});
      cycle(1'b0, 64'd0, 1'b0, 1'b1);

      // Reset mid-frame drops the stale half.
      do_reset();
      cycle(1'b1, 64'h5555_5555_5555_5555, 1'b0, 1'b1);
      do_reset();
      cycle(1'b1, 64'h1111_1111_1111_1111, 1'b0, 1'b1);
      cycle(1'b1, 64'h2222_2222_2222_2222, 1'b0, 1'b1);
      chk("t4_data", m_data, {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222});
      cycle(1'b0, 64'd0, 1'b0, 1'b1);

      // Single segment with tlast.
      do_reset();
      cycle(1'b1, 64'hCCCC_CCCC_CCCC_CCCC, 1'b1, 1'b1);
      chk("t5_valid", m_valid, TLAST_EN);
      chk("t5_keep",  m_keep,  TLAST_EN ? 16'hFF00 : 16'h0000);
      chk("t5_last",  m_last,  TLAST_EN);
      cycle(1'b1, 64'hDDDD_DDDD_DDDD_DDDD, 1'b0, 1'b1);
      cycle(1'b0, 64'd0, 1'b0, 1'b1);

      // Randomized traffic and backpressure.
      for (int k = 0; k < 800; k++) begin
         cycle($urandom_range(0, 3) != 0, {$urandom, $urandom},
               $urandom_range(0, 4) == 0, $urandom_range(0, 4) < 3);
      end
      for (int k = 0; k < 4; k++) cycle(1'b0, 64'd0, 1'b0, 1'b1);
      chk("drain_empty", 128'(exp_q.size()), 0);

      // 32/128: four segments, MSB-first.
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         s1_valid = 1'b1; s1_data = 32'(k); s1_last = 1'b0; m1_ready = 1'b0;
         @(posedge clk);
         #1;
         if (k == 3) chk("t6_early", m1_valid, 0);
      end
      chk("t6_valid", m1_valid, 1);
      chk("t6_data",  m1_data,  128'h00000001_00000002_00000003_00000004);
      chk("t6_keep",  m1_keep,  16'hFFFF);
      chk("t6_last",  m1_last,  0);
      @(negedge clk);
      s1_valid = 1'b0; m1_ready = 1'b1;

      // 64/64: combinational pass-through.
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         s2_data  = {$urandom, $urandom};
         s2_valid = 1'($urandom_range(0, 1));
         s2_last  = 1'($urandom_range(0, 1));
         m2_ready = 1'($urandom_range(0, 1));
         #1;
         chk("pt_data",  m2_data,  s2_data);
         chk("pt_valid", m2_valid, s2_valid);
         chk("pt_ready", s2_ready, m2_ready);
         chk("pt_keep",  m2_keep,  8'hFF);
         chk("pt_last",  m2_last,  TLAST_EN && s2_last);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
